// File: rtl/ddr3_rw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_rw_arbiter
// Function : urgent/round-robin write/read burst sequencer for the DDR3MI app port
// Revision : 1.0  initial release
// ============================================================================
module ddr3_rw_arbiter #(
  parameter int ADDR_WIDTH  = 28,
  parameter int DATA_WIDTH  = 128,
  parameter int BURST_BEATS = 64,
  parameter int TIMEOUT     = 4096
) (
  input  logic                    scaled_down_DDR3_clk,
  input  logic                    I_rst_n,
  input  logic                    init_calib_complete,
  input  logic                    wr_req,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic                    wr_gnt,
  output logic                    wr_pop,
  input  logic [DATA_WIDTH-1:0]   wr_beat_data,
  output logic                    wr_done,
  input  logic                    rd_req,
  input  logic                    rd_urgent,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    rd_gnt,
  output logic                    rd_beat_valid,
  output logic [DATA_WIDTH-1:0]   rd_beat_data,
  output logic                    rd_done,
  input  logic                    cmd_ready,
  output logic [2:0]              cmd,
  output logic                    cmd_en,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic [5:0]              app_burst_number,
  input  logic                    wr_data_rdy,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    wr_data_en,
  output logic                    wr_data_end,
  output logic [DATA_WIDTH/8-1:0] wr_data_mask,
  input  logic                    rd_data_valid,
  input  logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    err_timeout
);

  localparam int c_tmo_w = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARB     = 3'd1,
    S_WR_CMD  = 3'd2,
    S_RD_CMD  = 3'd3,
    S_WR_DATA = 3'd4,
    S_RD_DATA = 3'd5
  } state_t;

  state_t             r_state;
  logic               r_last_wr;
  logic [6:0]         r_beat_cnt;
  logic [c_tmo_w-1:0] r_tmo_cnt;

  logic w_wr_beat;
  logic w_rd_beat;
  logic w_last_beat;
  logic w_tmo_hit;
  logic w_pick_rd;
  logic w_pick_wr;

  assign w_wr_beat   = (r_state == S_WR_DATA) && wr_data_rdy;
  assign w_rd_beat   = (r_state == S_RD_DATA) && rd_data_valid;
  assign w_last_beat = (r_beat_cnt == 7'(BURST_BEATS - 1));
  assign w_tmo_hit   = (r_tmo_cnt == c_tmo_w'(TIMEOUT - 1));

  // Urgent reads win outright; otherwise alternate when both ports ask.
  assign w_pick_rd = rd_req && (rd_urgent || !wr_req || r_last_wr);
  assign w_pick_wr = wr_req && !w_pick_rd;

  // Handshake strobes must answer the DDR3MI ready flags in the same cycle.
  assign cmd_en           = ((r_state == S_WR_CMD) || (r_state == S_RD_CMD)) && cmd_ready;
  assign wr_pop           = w_wr_beat;
  assign wr_data_en       = w_wr_beat;
  assign wr_data_end      = w_wr_beat;
  assign wr_data          = wr_beat_data;
  assign wr_data_mask     = '0;
  assign app_burst_number = 6'(BURST_BEATS - 1);

  always_ff @(posedge scaled_down_DDR3_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state       <= S_IDLE;
      r_last_wr     <= 1'b1;
      r_beat_cnt    <= '0;
      r_tmo_cnt     <= '0;
      wr_gnt        <= 1'b0;
      rd_gnt        <= 1'b0;
      wr_done       <= 1'b0;
      rd_done       <= 1'b0;
      rd_beat_valid <= 1'b0;
      rd_beat_data  <= '0;
      cmd           <= 3'b000;
      addr          <= '0;
      err_timeout   <= 1'b0;
    end else begin
      wr_gnt        <= 1'b0;
      rd_gnt        <= 1'b0;
      wr_done       <= 1'b0;
      rd_done       <= 1'b0;
      rd_beat_valid <= w_rd_beat;
      if (w_rd_beat) rd_beat_data <= rd_data;

      case (r_state)
        S_IDLE: begin
          if (init_calib_complete) r_state <= S_ARB;
        end
        S_ARB: begin
          r_tmo_cnt  <= '0;
          r_beat_cnt <= '0;
          if (!init_calib_complete) begin
            r_state <= S_IDLE;
          end else if (w_pick_rd) begin
            rd_gnt    <= 1'b1;
            addr      <= rd_addr;
            cmd       <= 3'b001;
            r_last_wr <= 1'b0;
            r_state   <= S_RD_CMD;
          end else if (w_pick_wr) begin
            wr_gnt    <= 1'b1;
            addr      <= wr_addr;
            cmd       <= 3'b000;
            r_last_wr <= 1'b1;
            r_state   <= S_WR_CMD;
          end
        end
        S_WR_CMD: begin
          if (cmd_ready) begin
            r_tmo_cnt <= '0;
            r_state   <= S_WR_DATA;
          end else if (w_tmo_hit) begin
            err_timeout <= 1'b1;
            wr_done     <= 1'b1;
            r_state     <= S_ARB;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
          end
        end
        S_RD_CMD: begin
          if (cmd_ready) begin
            r_tmo_cnt <= '0;
            r_state   <= S_RD_DATA;
          end else if (w_tmo_hit) begin
            err_timeout <= 1'b1;
            rd_done     <= 1'b1;
            r_state     <= S_ARB;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
          end
        end
        S_WR_DATA: begin
          if (w_wr_beat) begin
            r_tmo_cnt <= '0;
            if (w_last_beat) begin
              wr_done <= 1'b1;
              r_state <= S_ARB;
            end else begin
              r_beat_cnt <= r_beat_cnt + 7'd1;
            end
          end else if (w_tmo_hit) begin
            err_timeout <= 1'b1;
            wr_done     <= 1'b1;
            r_state     <= S_ARB;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
          end
        end
        S_RD_DATA: begin
          // rd_done lands on the same edge as the registered last beat.
          if (w_rd_beat) begin
            r_tmo_cnt <= '0;
            if (w_last_beat) begin
              rd_done <= 1'b1;
              r_state <= S_ARB;
            end else begin
              r_beat_cnt <= r_beat_cnt + 7'd1;
            end
          end else if (w_tmo_hit) begin
            err_timeout <= 1'b1;
            rd_done     <= 1'b1;
            r_state     <= S_ARB;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ddr3_rw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr3_rw_arbiter
// Function : directed self-checking bench for ddr3_rw_arbiter (TIMEOUT = 16)
// Revision : 1.0  initial release
// ============================================================================
module tb_ddr3_rw_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          I_rst_n = 1'b0;
  logic          init_calib_complete = 1'b0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic          wr_gnt;
  logic          wr_pop;
  logic [DW-1:0] wr_beat_data = '0;
  logic          wr_done;
  logic          rd_req = 1'b0;
  logic          rd_urgent = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_gnt;
  logic          rd_beat_valid;
  logic [DW-1:0] rd_beat_data;
  logic          rd_done;
  logic          cmd_ready = 1'b0;
  logic [2:0]    cmd;
  logic          cmd_en;
  logic [AW-1:0] addr;
  logic [5:0]    app_burst_number;
  logic          wr_data_rdy = 1'b0;
  logic [DW-1:0] wr_data;
  logic          wr_data_en;
  logic          wr_data_end;
  logic [DW/8-1:0] wr_data_mask;
  logic          rd_data_valid = 1'b0;
  logic [DW-1:0] rd_data = '0;
  logic          err_timeout;

  ddr3_rw_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BURST_BEATS(64),
    .TIMEOUT    (16)
  ) dut (
    .scaled_down_DDR3_clk(clk),
    .I_rst_n             (I_rst_n),
    .init_calib_complete (init_calib_complete),
    .wr_req              (wr_req),
    .wr_addr             (wr_addr),
    .wr_gnt              (wr_gnt),
    .wr_pop              (wr_pop),
    .wr_beat_data        (wr_beat_data),
    .wr_done             (wr_done),
    .rd_req              (rd_req),
    .rd_urgent           (rd_urgent),
    .rd_addr             (rd_addr),
    .rd_gnt              (rd_gnt),
    .rd_beat_valid       (rd_beat_valid),
    .rd_beat_data        (rd_beat_data),
    .rd_done             (rd_done),
    .cmd_ready           (cmd_ready),
    .cmd                 (cmd),
    .cmd_en              (cmd_en),
    .addr                (addr),
    .app_burst_number    (app_burst_number),
    .wr_data_rdy         (wr_data_rdy),
    .wr_data             (wr_data),
    .wr_data_en          (wr_data_en),
    .wr_data_end         (wr_data_end),
    .wr_data_mask        (wr_data_mask),
    .rd_data_valid       (rd_data_valid),
    .rd_data             (rd_data),
    .err_timeout         (err_timeout)
  );

  always #5 clk = ~clk;

  // Event monitor, sampled on the falling edge.
  int cyc = 0;
  int cnt_gnt = 0, cnt_cmd_en = 0, cnt_wr_beat = 0, cnt_rd_beat = 0;
  int cnt_done = 0, rd_done_nobeat = 0, viol = 0;
  int last_wr_beat_cyc = 0, wr_done_gap = 0;
  logic [DW-1:0] last_rd_data = '0;
  bit   outstanding = 1'b0;
  bit   glog [0:63];
  int   n_glog = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!I_rst_n) begin
      outstanding <= 1'b0;
    end else begin
      if (wr_gnt || rd_gnt) begin
        cnt_gnt <= cnt_gnt + 1;
        if (outstanding) viol <= viol + 1;
        outstanding <= 1'b1;
        if (n_glog < 64) begin
          glog[n_glog] <= wr_gnt;
          n_glog <= n_glog + 1;
        end
      end
      if (wr_done || rd_done) begin
        cnt_done <= cnt_done + 1;
        outstanding <= 1'b0;
      end
      if (cmd_en) cnt_cmd_en <= cnt_cmd_en + 1;
      if (wr_data_en) begin
        cnt_wr_beat <= cnt_wr_beat + 1;
        last_wr_beat_cyc <= cyc;
      end
      if (wr_done) wr_done_gap <= cyc - last_wr_beat_cyc;
      if (rd_beat_valid) begin
        cnt_rd_beat <= cnt_rd_beat + 1;
        last_rd_data <= rd_beat_data;
      end
      if (rd_done && !rd_beat_valid) rd_done_nobeat <= rd_done_nobeat + 1;
    end
  end

  int  n_pass = 0;
  int  n_tot  = 0;
  bit  tgl    = 1'b0;
  int  b, s_wr, s_rd, s_cmd, s_nob;
  logic [3:0] order;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (tgl) wr_data_rdy = ~wr_data_rdy;
  endtask

  task automatic wait_gnt(input string tag, input int max);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(wr_gnt || rd_gnt) && n < max);
    chk(tag, (wr_gnt || rd_gnt), 1'b1);
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(wr_done || rd_done) && n < max);
    chk(tag, (wr_done || rd_done), 1'b1);
  endtask

  task automatic snap();
    s_wr  = cnt_wr_beat;
    s_rd  = cnt_rd_beat;
    s_cmd = cnt_cmd_en;
    s_nob = rd_done_nobeat;
    b     = n_glog;
  endtask

  initial begin
    // Reset state
    wr_req = 1'b1; wr_addr = 28'h123_4560; cmd_ready = 1'b1; wr_data_rdy = 1'b1;
    wr_beat_data = {4{32'hCAFE_0001}};
    repeat (3) tick();
    chk("rst_wr_gnt", wr_gnt, 1'b0);
    chk("rst_cmd_en", cmd_en, 1'b0);
    chk("rst_cmd", cmd, 3'b000);
    chk("rst_addr", addr, '0);
    chk("rst_err", err_timeout, 1'b0);
    chk("rst_wr_data_en", wr_data_en, 1'b0);
    chk("burst_number", app_burst_number, 6'd63);
    chk("data_mask", wr_data_mask, '0);
    I_rst_n = 1'b1;

    // Test 1: no grant before calibration, then one full write burst
    repeat (10) tick();
    chk("t1_nogrant", cnt_gnt, 0);
    chk("t1_nocmd", cnt_cmd_en, 0);
    init_calib_complete = 1'b1;
    snap();
    tick();
    chk("t1_arb_gnt", wr_gnt, 1'b0);
    tick();
    chk("t1_wr_gnt", wr_gnt, 1'b1);
    chk("t1_addr", addr, 28'h123_4560);
    chk("t1_cmd", cmd, 3'b000);
    chk("t1_cmd_en", cmd_en, 1'b1);
    wr_req = 1'b0;
    tick();
    chk("t1_cmd_en_once", cmd_en, 1'b0);
    chk("t1_wr_data_en", wr_data_en, 1'b1);
    chk("t1_wr_data", wr_data, {4{32'hCAFE_0001}});
    wait_done("t1_done_wait", 200);
    chk("t1_done_is_wr", wr_done, 1'b1);
    tick();
    chk("t1_beats", cnt_wr_beat - s_wr, 64);
    chk("t1_cmd_en_cnt", cnt_cmd_en - s_cmd, 1);
    chk("t1_done_gap", wr_done_gap, 1);

    // Test 4: wr_data_rdy toggling every cycle
    snap();
    tgl = 1'b1;
    wr_addr = 28'h0AB_CDE0; wr_req = 1'b1;
    wait_gnt("t4_gnt_wait", 20);
    chk("t4_addr", addr, 28'h0AB_CDE0);
    wr_req = 1'b0;
    wait_done("t4_done_wait", 400);
    tick();
    tgl = 1'b0; wr_data_rdy = 1'b1;
    chk("t4_beats", cnt_wr_beat - s_wr, 64);
    chk("t4_done_gap", wr_done_gap, 1);
    chk("t4_err", err_timeout, 1'b0);

    // Test 2: both ports requesting, no urgency -> alternate R,W,R,W
    snap();
    rd_data = {4{32'h5A5A_1234}}; rd_data_valid = 1'b1;
    rd_addr = 28'h777_0000;
    wr_req = 1'b1; rd_req = 1'b1;
    for (int i = 0; i < 4; i++) wait_done("t2_done_wait", 300);
    wr_req = 1'b0; rd_req = 1'b0;
    tick();
    chk("t2_grants", n_glog - b, 4);
    order = {glog[b], glog[b+1], glog[b+2], glog[b+3]};
    chk("t2_order", order, 4'b0101);
    chk("t2_rd_beats", cnt_rd_beat - s_rd, 128);
    chk("t2_wr_beats", cnt_wr_beat - s_wr, 128);
    chk("t2_rd_done_align", rd_done_nobeat - s_nob, 0);
    chk("t2_rd_data", last_rd_data, {4{32'h5A5A_1234}});
    chk("t2_no_overlap", viol, 0);

    // Test 3: urgent read during a write wins the next two grants
    snap();
    wr_req = 1'b1;
    wait_gnt("t3_gnt1", 20);
    rd_req = 1'b1; rd_urgent = 1'b1;
    wait_done("t3_done1", 200);
    wait_gnt("t3_gnt2", 20);
    chk("t3_gnt2_is_rd", rd_gnt, 1'b1);
    chk("t3_cmd_rd", cmd, 3'b001);
    chk("t3_addr_rd", addr, 28'h777_0000);
    wait_done("t3_done2", 200);
    wait_gnt("t3_gnt3", 20);
    rd_urgent = 1'b0;
    wait_done("t3_done3", 200);
    wait_gnt("t3_gnt4", 20);
    wr_req = 1'b0; rd_req = 1'b0;
    wait_done("t3_done4", 200);
    tick();
    order = {glog[b], glog[b+1], glog[b+2], glog[b+3]};
    chk("t3_order", order, 4'b1001);
    chk("t3_grants", n_glog - b, 4);

    // Test 5: read with no data -> timeout after 16 cycles in RD_DATA
    rd_data_valid = 1'b0; rd_req = 1'b1;
    wait_gnt("t5_gnt_wait", 20);
    chk("t5_is_rd", rd_gnt, 1'b1);
    rd_req = 1'b0;
    tick();
    repeat (15) tick();
    chk("t5_err_early", err_timeout, 1'b0);
    chk("t5_done_early", rd_done, 1'b0);
    tick();
    chk("t5_err", err_timeout, 1'b1);
    chk("t5_rd_done", rd_done, 1'b1);
    chk("t5_no_beat", rd_beat_valid, 1'b0);
    snap();
    wr_req = 1'b1; rd_data_valid = 1'b1;
    tick();
    chk("t5_back_in_arb", wr_gnt, 1'b1);
    chk("t5_err_sticky", err_timeout, 1'b1);
    wr_req = 1'b0;
    wait_done("t5_wr_done_wait", 200);
    tick();
    chk("t5_stray_rd_dropped", cnt_rd_beat - s_rd, 0);
    rd_data_valid = 1'b0;

    // Test 6: async reset at beat 10 of a write, then a clean burst
    wr_req = 1'b1; wr_addr = 28'h0F0_0F00;
    wait_gnt("t6_gnt_wait", 20);
    wr_req = 1'b0;
    tick();
    repeat (9) tick();
    chk("t6_mid_burst", wr_data_en, 1'b1);
    I_rst_n = 1'b0;
    #1;
    chk("t6_rst_wr_data_en", wr_data_en, 1'b0);
    chk("t6_rst_wr_pop", wr_pop, 1'b0);
    chk("t6_rst_addr", addr, '0);
    chk("t6_rst_err", err_timeout, 1'b0);
    repeat (2) tick();
    I_rst_n = 1'b1;
    repeat (3) tick();
    snap();
    wr_req = 1'b1; wr_addr = 28'h0F0_1000;
    wait_gnt("t6_gnt2_wait", 20);
    chk("t6_addr", addr, 28'h0F0_1000);
    wr_req = 1'b0;
    wait_done("t6_done_wait", 200);
    tick();
    chk("t6_beats", cnt_wr_beat - s_wr, 64);
    chk("t6_cmd_en_cnt", cnt_cmd_en - s_cmd, 1);
    chk("t6_err", err_timeout, 1'b0);
    chk("t6_done_gap", wr_done_gap, 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
